// File: rtl/alu_issue_if.sv
// Bundle between the two issue lanes, the arbiter, the execute-stage ALU and
// the writeback ports. master = issue lanes / ALU / writeback side,
// slave = the arbiter.
interface alu_issue_if;
  // Lane 0 decoded operation
  logic        l0_valid;
  logic        l0_ready;
  logic [11:0] l0_alusignals;
  logic [15:0] l0_op1;
  logic [15:0] l0_op2;
  logic [4:0]  l0_immx;
  logic        l0_isimm;
  logic [2:0]  l0_rd;
  // Lane 1 decoded operation
  logic        l1_valid;
  logic        l1_ready;
  logic [11:0] l1_alusignals;
  logic [15:0] l1_op1;
  logic [15:0] l1_op2;
  logic [4:0]  l1_immx;
  logic        l1_isimm;
  logic [2:0]  l1_rd;
  // Registered ALU drive and returning result
  logic [11:0] alu_signals;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [4:0]  alu_immx;
  logic        alu_isimm;
  logic [15:0] alu_instr;
  logic [15:0] alu_result;
  // Writeback
  logic        wb_valid;
  logic        wb_lane;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        busy;

  modport master (
    output l0_valid, l0_alusignals, l0_op1, l0_op2, l0_immx, l0_isimm, l0_rd,
    output l1_valid, l1_alusignals, l1_op1, l1_op2, l1_immx, l1_isimm, l1_rd,
    output alu_result,
    input  l0_ready, l1_ready,
    input  alu_signals, alu_op1, alu_op2, alu_immx, alu_isimm, alu_instr,
    input  wb_valid, wb_lane, wb_rd, wb_data, busy
  );

  modport slave (
    input  l0_valid, l0_alusignals, l0_op1, l0_op2, l0_immx, l0_isimm, l0_rd,
    input  l1_valid, l1_alusignals, l1_op1, l1_op2, l1_immx, l1_isimm, l1_rd,
    input  alu_result,
    output l0_ready, l1_ready,
    output alu_signals, alu_op1, alu_op2, alu_immx, alu_isimm, alu_instr,
    output wb_valid, wb_lane, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one execute-stage ALU between two issue lanes.
// Registers the granted op into the ALU issue stage, stalls issue while a
// multiply holds the ALU, and carries {lane, rd} down a tag pipe matched to
// the ALU latency so each result returns to the lane that issued it.
module alu_issue_arbiter #(
  parameter int ALU_LAT    = 2,
  parameter int MUL_CYCLES = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_issue_if.slave  bus
);

  typedef enum logic {S_IDLE, S_MULWAIT} state_t;

  typedef struct packed {
    logic [11:0] sig;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimm;
    logic [2:0]  rd;
  } op_t;

  typedef struct packed {
    logic       v;
    logic       lane;
    logic [2:0] rd;
  } tag_t;

  localparam int            CW        = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam bit            MUL_HOLDS = (MUL_CYCLES > 1);
  localparam logic [CW-1:0] MUL_LOAD  = CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 0);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ptr_q, ptr_d;
  op_t                    iss_q, iss_d;       // registered ALU drive
  logic                   iss_lane_q, iss_lane_d;
  logic                   iss_wr_q, iss_wr_d;  // issued op writes a register
  logic                   fresh_q, fresh_d;    // non-mul issued on the last edge
  tag_t [ALU_LAT-1:0]     tag_q, tag_d;

  logic can_issue;
  logic sel_l1;
  logic xfer;
  logic sel_mul;
  op_t  l0_op, l1_op, sel_op;
  tag_t ins;
  logic any_tag;

  assign l0_op = op_t'{bus.l0_alusignals, bus.l0_op1, bus.l0_op2,
                       bus.l0_immx, bus.l0_isimm, bus.l0_rd};
  assign l1_op = op_t'{bus.l1_alusignals, bus.l1_op1, bus.l1_op2,
                       bus.l1_immx, bus.l1_isimm, bus.l1_rd};

  // Arbitration: issue opens in IDLE or on the MULWAIT return cycle (cnt = 0)
  always_comb begin
    can_issue    = rst_n && ((state_q == S_IDLE) || (cnt_q == '0));
    sel_l1       = bus.l1_valid && (!bus.l0_valid || ptr_q);
    xfer         = can_issue && (bus.l0_valid || bus.l1_valid);
    bus.l0_ready = xfer && !sel_l1;
    bus.l1_ready = xfer && sel_l1;
    sel_op       = sel_l1 ? l1_op : l0_op;
    sel_mul      = sel_op.sig[4] && MUL_HOLDS;
  end

  // Next state of FSM, pointer and issue registers
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    iss_d      = iss_q;
    iss_lane_d = iss_lane_q;
    iss_wr_d   = iss_wr_q;
    fresh_d    = 1'b0;
    if (xfer) begin
      iss_d      = sel_op;
      iss_lane_d = sel_l1;
      iss_wr_d   = (sel_op.sig != '0) && !sel_op.sig[2] && !sel_op.sig[5];
      ptr_d      = !sel_l1;
      if (sel_mul) begin
        state_d = S_MULWAIT;
        cnt_d   = MUL_LOAD;
      end else begin
        state_d = S_IDLE;
        fresh_d = 1'b1;
      end
    end else if (can_issue) begin
      // Bubble: only the op bits drop, operands hold
      iss_d.sig = '0;
      state_d   = S_IDLE;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Tag pipe: one entry inserted every edge, valid only for register writers
  always_comb begin
    ins.v    = iss_wr_q && (fresh_q || ((state_q == S_MULWAIT) && (cnt_q == '0)));
    ins.lane = iss_lane_q;
    ins.rd   = iss_q.rd;
    tag_d[0] = ins;
    for (int i = 1; i < ALU_LAT; i++) tag_d[i] = tag_q[i-1];
    any_tag = 1'b0;
    for (int i = 0; i < ALU_LAT; i++) any_tag = any_tag | tag_q[i].v;
  end

  // State registers with synchronous reset; in-flight tags are dropped
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst_n) begin
      // NOTE: the tag pipe is reset like any other flop; stale valid bits
      // would otherwise produce writebacks for dropped operations.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      iss_q      <= '0;
      iss_lane_q <= 1'b0;
      iss_wr_q   <= 1'b0;
      fresh_q    <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      iss_q      <= iss_d;
      iss_lane_q <= iss_lane_d;
      iss_wr_q   <= iss_wr_d;
      fresh_q    <= fresh_d;
      tag_q      <= tag_d;
    end
  end

  assign bus.alu_signals = iss_q.sig;
  assign bus.alu_op1     = iss_q.op1;
  assign bus.alu_op2     = iss_q.op2;
  assign bus.alu_immx    = iss_q.immx;
  assign bus.alu_isimm   = iss_q.isimm;
  assign bus.alu_instr   = {5'b0, iss_q.rd, 8'b0};

  assign bus.wb_valid = tag_q[ALU_LAT-1].v;
  assign bus.wb_lane  = tag_q[ALU_LAT-1].lane;
  assign bus.wb_rd    = tag_q[ALU_LAT-1].rd;
  assign bus.wb_data  = tag_q[ALU_LAT-1].v ? bus.alu_result : 16'h0000;
  assign bus.busy     = (state_q == S_MULWAIT) || any_tag;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed lane stimulus, a pipelined ALU model
// feeding alu_result, and a writeback scoreboard filled at each handshake.
module tb_alu_issue_arbiter;

  localparam int ALU_LAT    = 2;
  localparam int MUL_CYCLES = 3;

  typedef struct {
    logic        lane;
    logic [2:0]  rd;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic g0, g1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [15:0] alu_pipe [ALU_LAT];

  alu_issue_if bus ();

  alu_issue_arbiter #(.ALU_LAT(ALU_LAT), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(logic [11:0] s, logic [15:0] a,
                                         logic [15:0] b, logic [4:0] imm,
                                         logic isimm);
    logic [15:0] y;
    y = isimm ? {11'd0, imm} : b;
    if (s[4])                    return a * y;
    else if (s[0] | s[1] | s[2]) return a + y;
    else if (s[3] | s[5])        return a - y;
    else if (s[6])               return y;
    else if (s[7])               return a | y;
    else if (s[8])               return a & y;
    else if (s[9])               return ~a;
    else if (s[10])              return a << y[3:0];
    else if (s[11])              return a >> y[3:0];
    else                         return 16'h0000;
  endfunction

  function automatic bit writes(logic [11:0] s);
    return (s != 12'h000) && !s[2] && !s[5];
  endfunction

  // ALU model: result appears ALU_LAT edges after the issue stage is sampled
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(bus.alu_signals, bus.alu_op1, bus.alu_op2,
                          bus.alu_immx, bus.alu_isimm);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign bus.alu_result = alu_pipe[ALU_LAT-1];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writeback monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_lane", bus.wb_lane, e.lane);
          check("wb_rd",   bus.wb_rd,   e.rd);
          check("wb_data", bus.wb_data, e.data);
        end
      end else begin
        check("wb_data_idle", bus.wb_data, 32'd0);
      end
    end
  end

  task automatic set_lane(input int lane, input logic v, input logic [11:0] s,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] imm, input logic isimm,
                          input logic [2:0] rd);
    if (lane == 0) begin
      bus.l0_valid = v; bus.l0_alusignals = s; bus.l0_op1 = a; bus.l0_op2 = b;
      bus.l0_immx = imm; bus.l0_isimm = isimm; bus.l0_rd = rd;
    end else begin
      bus.l1_valid = v; bus.l1_alusignals = s; bus.l1_op1 = a; bus.l1_op2 = b;
      bus.l1_immx = imm; bus.l1_isimm = isimm; bus.l1_rd = rd;
    end
  endtask

  task automatic idle_lanes();
    set_lane(0, 1'b0, 12'h000, 16'h0, 16'h0, 5'h0, 1'b0, 3'h0);
    set_lane(1, 1'b0, 12'h000, 16'h0, 16'h0, 5'h0, 1'b0, 3'h0);
  endtask

  task automatic to_drive();
    @(negedge clk);
    #1;
  endtask

  // Sample readies late in the cycle, record transfers, advance past the edge
  task automatic tick();
    #2;
    g0 = bus.l0_ready;
    g1 = bus.l1_ready;
    if (g0 && bus.l0_valid && writes(bus.l0_alusignals))
      sb.push_back('{1'b0, bus.l0_rd, alu_fn(bus.l0_alusignals, bus.l0_op1,
                     bus.l0_op2, bus.l0_immx, bus.l0_isimm)});
    if (g1 && bus.l1_valid && writes(bus.l1_alusignals))
      sb.push_back('{1'b1, bus.l1_rd, alu_fn(bus.l1_alusignals, bus.l1_op1,
                     bus.l1_op2, bus.l1_immx, bus.l1_isimm)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    to_drive(); idle_lanes(); rst_n = 1'b0; tick();
    sb.delete();
    to_drive(); rst_n = 1'b1; tick();
  endtask

  task automatic drain(input string tag);
    repeat (ALU_LAT + MUL_CYCLES + 2) begin
      to_drive(); idle_lanes(); tick();
    end
    check(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_lanes();
    // Reset state with a lane asserting valid
    to_drive(); set_lane(0, 1'b1, 12'h001, 16'd1, 16'd1, 5'd0, 1'b0, 3'd1);
    tick(); tick();
    check("rst_l0_ready", bus.l0_ready, 1'b0);
    check("rst_l1_ready", bus.l1_ready, 1'b0);
    check("rst_alu_signals", bus.alu_signals, 12'h000);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    to_drive(); idle_lanes(); rst_n = 1'b1; tick();

    // Single add on l0: 5 + 7 -> rd 3
    to_drive(); set_lane(0, 1'b1, 12'h001, 16'd5, 16'd7, 5'd0, 1'b0, 3'd3); tick();
    check("t1_l0_ready", g0, 1'b1);
    check("t1_l1_ready", g1, 1'b0);
    check("t1_alu_signals", bus.alu_signals, 12'h001);
    check("t1_alu_op1", bus.alu_op1, 16'd5);
    check("t1_alu_instr", bus.alu_instr, 16'h0300);
    to_drive(); idle_lanes(); tick();
    check("t1_bubble_sig", bus.alu_signals, 12'h000);
    check("t1_bubble_op2_hold", bus.alu_op2, 16'd7);
    to_drive(); tick();
    check("t1_wb_valid", bus.wb_valid, 1'b1);
    check("t1_wb_rd", bus.wb_rd, 3'd3);
    check("t1_wb_data", bus.wb_data, 16'd12);
    drain("t1_drain");

    // Both lanes valid with sub ops: grants alternate from lane 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      to_drive();
      set_lane(0, 1'b1, 12'h008, 16'(100 + i), 16'(i), 5'd0, 1'b0, 3'(i));
      set_lane(1, 1'b1, 12'h008, 16'(50 + 3 * i), 16'(2 * i), 5'd0, 1'b0, 3'(7 - i));
      tick();
      check("t2_grant_l0", g0, (i % 2) == 0);
      check("t2_grant_l1", g1, (i % 2) == 1);
    end
    drain("t2_drain");

    // l1 multiply 6 x 7 holds the ALU; l0 waits and wins the return cycle
    do_reset();
    to_drive(); set_lane(1, 1'b1, 12'h010, 16'd6, 16'd7, 5'd0, 1'b0, 3'd2); tick();
    check("t3_mul_grant", g1, 1'b1);
    check("t3_mul_sig", bus.alu_signals, 12'h010);
    check("t3_busy", bus.busy, 1'b1);
    for (int k = 0; k < MUL_CYCLES - 1; k++) begin
      to_drive(); idle_lanes();
      set_lane(0, 1'b1, 12'h001, 16'd1, 16'd1, 5'd0, 1'b0, 3'd1); tick();
      check("t3_stall_l0", g0, 1'b0);
      check("t3_stall_l1", g1, 1'b0);
      check("t3_hold_sig", bus.alu_signals, 12'h010);
      check("t3_hold_op1", bus.alu_op1, 16'd6);
      check("t3_hold_op2", bus.alu_op2, 16'd7);
    end
    to_drive(); tick();
    check("t3_return_grant", g0, 1'b1);
    check("t3_return_sig", bus.alu_signals, 12'h001);
    drain("t3_drain");

    // st, cmp and all-zero ops are issued but never write back
    to_drive(); set_lane(0, 1'b1, 12'h004, 16'd3, 16'd4, 5'd0, 1'b0, 3'd1); tick();
    check("t4_st_grant", g0, 1'b1);
    check("t4_st_sig", bus.alu_signals, 12'h004);
    to_drive(); set_lane(0, 1'b1, 12'h020, 16'd3, 16'd4, 5'd0, 1'b0, 3'd2); tick();
    check("t4_cmp_grant", g0, 1'b1);
    check("t4_cmp_sig", bus.alu_signals, 12'h020);
    to_drive(); set_lane(0, 1'b1, 12'h000, 16'd3, 16'd4, 5'd0, 1'b0, 3'd3); tick();
    check("t4_zero_grant", g0, 1'b1);
    check("t4_zero_sig", bus.alu_signals, 12'h000);
    drain("t4_drain");

    // Reset during MULWAIT with tags in flight
    do_reset();
    to_drive(); set_lane(0, 1'b1, 12'h001, 16'd1, 16'd2, 5'd0, 1'b0, 3'd1); tick();
    to_drive(); idle_lanes();
    set_lane(1, 1'b1, 12'h008, 16'd9, 16'd4, 5'd0, 1'b0, 3'd2); tick();
    to_drive(); idle_lanes();
    set_lane(0, 1'b1, 12'h010, 16'd3, 16'd3, 5'd0, 1'b0, 3'd4); tick();
    check("t5_in_mulwait", bus.busy, 1'b1);
    to_drive(); rst_n = 1'b0;
    set_lane(0, 1'b1, 12'h001, 16'd1, 16'd1, 5'd0, 1'b0, 3'd1);
    set_lane(1, 1'b1, 12'h001, 16'd1, 16'd1, 5'd0, 1'b0, 3'd1);
    tick();
    sb.delete();
    check("t5_rst_l0_ready", bus.l0_ready, 1'b0);
    check("t5_rst_l1_ready", bus.l1_ready, 1'b0);
    check("t5_rst_alu_sig", bus.alu_signals, 12'h000);
    check("t5_rst_alu_op1", bus.alu_op1, 16'd0);
    check("t5_rst_alu_instr", bus.alu_instr, 16'h0000);
    check("t5_rst_wb_valid", bus.wb_valid, 1'b0);
    check("t5_rst_busy", bus.busy, 1'b0);
    to_drive(); rst_n = 1'b1; idle_lanes();
    set_lane(1, 1'b1, 12'h001, 16'd10, 16'd10, 5'd0, 1'b0, 3'd5); tick();
    check("t5_l1_only_grant", g1, 1'b1);
    to_drive();
    set_lane(0, 1'b1, 12'h001, 16'd20, 16'd1, 5'd0, 1'b0, 3'd6);
    set_lane(1, 1'b1, 12'h001, 16'd30, 16'd1, 5'd0, 1'b0, 3'd7); tick();
    check("t5_ptr_l0_grant", g0, 1'b1);
    check("t5_ptr_l1_wait", g1, 1'b0);
    drain("t5_drain");

    // Immediate operand on l1: lsl 3 by immx 9 -> rd 6
    to_drive(); idle_lanes();
    set_lane(1, 1'b1, 12'h400, 16'd3, 16'hFFFF, 5'd9, 1'b1, 3'd6); tick();
    check("t6_grant", g1, 1'b1);
    check("t6_alu_sig", bus.alu_signals, 12'h400);
    check("t6_alu_immx", bus.alu_immx, 5'd9);
    check("t6_alu_isimm", bus.alu_isimm, 1'b1);
    check("t6_alu_instr", bus.alu_instr, 16'h0600);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
